// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    // Default operand width (signed two's complement, legal 2..16).
    localparam int BOOTH_DEFAULT_WIDTH = 4;

    // Encoding of the examined pair {Q[0], q_m1}.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

endpackage

// File: rtl/booth_step_unit.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, q_m1} by one bit.
module booth_step_unit
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // Add/sub on WIDTH+1 bits so M = -2^(WIDTH-1) cannot overflow, then shift.
    always_comb begin
        m_ext = {m[WIDTH-1], m};
        sum   = a;
        case ({q[0], q_m1})
            BOOTH_ADD: sum = a + m_ext;
            BOOTH_SUB: sum = a - m_ext;
            default:   sum = a;
        endcase
        a_next    = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller. A single step unit is
// reused for WIDTH cycles; operands arrive on a valid/ready handshake and
// the product is held on a second valid/ready handshake.
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1; the producer holds valid and data until then.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter  int WIDTH = BOOTH_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   m_in,
    input  logic [WIDTH-1:0]   q_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    booth_state_t       state;
    booth_state_t       state_next;

    logic [WIDTH:0]     a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q_m1_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product_reg;

    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   q_step;
    logic               q_m1_step;

    logic               last_step;

    assign last_step = (cnt == CNT_W'(1));
    assign product   = product_reg;

    booth_step_unit #(.WIDTH(WIDTH)) u_step (
        .a         (a_reg),
        .q         (q_reg),
        .q_m1      (q_m1_reg),
        .m         (m_reg),
        .a_next    (a_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs, decoded from the current state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate in RUN, capture the product
    // on the final step. Product holds its value until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            m_reg       <= '0;
            cnt         <= '0;
            product_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg    <= m_in;
                        q_reg    <= q_in;
                        q_m1_reg <= 1'b0;
                        a_reg    <= '0;
                        cnt      <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    a_reg    <= a_step;
                    q_reg    <= q_step;
                    q_m1_reg <= q_m1_step;
                    cnt      <= cnt - CNT_W'(1);
                    if (last_step) product_reg <= {a_step[WIDTH-1:0], q_step};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH=4).
module tb_booth_seq_ctrl;
  localparam int W = 4;
  localparam int P = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] m_in, q_in;
  logic [P-1:0] product;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_in      (m_in),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    return P'(ai * bi);
  endfunction

  // ---------------- behavioural model ----------------
  // Transaction-level view: a job is pending from its accept edge until its
  // output handshake; the result is visible WIDTH edges after acceptance.
  bit           chk_en = 0;
  bit           pending = 0;
  int           cyc = 0;
  int           accept_cyc = 0;
  logic [P-1:0] exp_prod = '0;
  logic [P-1:0] last_prod = '0;
  logic [P-1:0] exp_q[$];

  always @(posedge clk) begin
    bit ov;
    ov = pending && (cyc - accept_cyc >= W);
    cyc++;
    if (rst) begin
      pending   = 0;
      last_prod = '0;
      exp_q.delete();
      chk_en    = 1;
    end else if (ov && out_ready) begin
      pending = 0;
    end else if (!pending && in_valid) begin
      pending    = 1;
      accept_cyc = cyc;
      exp_prod   = ref_mul(m_in, q_in);
      exp_q.push_back(exp_prod);
    end
    if (!rst && pending && (cyc - accept_cyc == W)) begin
      last_prod = exp_q.pop_front();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 16'(out_valid), 16'(pending && (cyc - accept_cyc >= W)));
      chk("in_ready",  16'(in_ready),  16'(!pending));
      chk("busy",      16'(busy),      16'(pending));
      chk("product",   16'(product),   16'(last_prod));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 16'(in_ready), 16'd1);
  endtask

  // Run one transaction. hold: cycles of backpressure in DONE.
  // toggle: wiggle in_valid during DONE. noise: drive other operands in RUN.
  task automatic run_txn(input logic [W-1:0] mv, input logic [W-1:0] qv,
                         input int hold, input bit toggle, input bit noise,
                         input logic [P-1:0] lit, input string nm);
    int lat;
    wait_in_ready();
    m_in = mv; q_in = qv; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    if (noise) begin
      m_in = ~mv; q_in = qv + 4'd1;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({nm, "_latency"}, 16'(lat), 16'(W));
    chk({nm, "_lit"}, 16'(product), 16'(lit));
    for (int i = 0; i < hold; i++) begin
      if (toggle) begin
        in_valid = i[0]; m_in = 4'(i); q_in = 4'(i + 3);
      end
      @(negedge clk);
      chk({nm, "_hold_valid"}, 16'(out_valid), 16'd1);
      chk({nm, "_hold_lit"}, 16'(product), 16'(lit));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_in_ready_after"}, 16'(in_ready), 16'd1);
    chk({nm, "_product_kept"}, 16'(product), 16'(lit));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev_acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; m_in = '0; q_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_product",   16'(product),   16'd0);
    chk("rst_busy",      16'(busy),      16'd0);

    // Directed vectors with hand-computed products.
    run_txn(4'd3,  4'd5,  0, 0, 0, 8'h0F, "m3_q5");
    run_txn(4'h8,  4'h8,  0, 0, 0, 8'h40, "mneg8_qneg8");
    run_txn(4'h8,  4'd7,  0, 0, 0, 8'hC8, "mneg8_q7");
    run_txn(4'd7,  4'hF,  0, 0, 0, 8'hF9, "m7_qneg1");
    run_txn(4'd5,  4'hD, 10, 1, 0, 8'hF1, "backpressure");
    run_txn(4'd6,  4'd2,  2, 0, 1, 8'h0C, "run_ignore");

    // Exhaustive sweep, back-to-back, out_ready held high.
    out_ready = 1'b1;
    prev_acc = -1;
    for (int mi = 0; mi < 16; mi++) begin
      for (int qi = 0; qi < 16; qi++) begin
        wait_in_ready();
        m_in = 4'(mi); q_in = 4'(qi); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (prev_acc >= 0) chk("txn_period", 16'(accept_cyc - prev_acc), 16'd6);
        prev_acc = accept_cyc;
      end
    end
    wait_in_ready();
    out_ready = 1'b0;
    chk("sweep_last", 16'(product), 16'h01);

    // Reset during RUN cycle 2 aborts the job.
    m_in = 4'd7; q_in = 4'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  16'(in_ready),  16'd1);
    chk("abort_out_valid", 16'(out_valid), 16'd0);
    chk("abort_product",   16'(product),   16'd0);
    chk("abort_busy",      16'(busy),      16'd0);
    run_txn(4'd2, 4'd3, 0, 0, 0, 8'h06, "after_abort");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
